hdmi_link_monitor: RTL and testbench

Supervises the incoming HDMI link in the system clock domain and generalises the top-level invalid-counter reset and vsync counter into one block. It synchronises hdmi_valid, vsync and hsync, generates a hysteretic hdmi_reset for the TMDS decoder, and measures the frame period and line count. It declares lock only after a parametrised number of consistent frames. The block sits beside tmds_decoder/hdmi_stream; its outputs feed display modules and debug GPIO.

---
 rtl/hdmi_link_monitor.sv | 172 +++++++++++++++++
 tb/tb_hdmi_link_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_link_monitor.sv
// hdmi_link_monitor: synchronises HDMI link status, drives a hysteretic decoder reset and measures/locks on frame timing
module hdmi_link_monitor #(
    parameter int INVALID_BITS = 21,
    parameter int LOCK_FRAMES  = 4,
    parameter int FRAME_BITS   = 24,
    parameter int LINE_BITS    = 12,
    parameter int TOL_SHIFT    = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hdmi_valid,
    input  logic                  vsync,
    input  logic                  hsync,
    output logic                  hdmi_reset,
    output logic                  locked,
    output logic [1:0]            state,
    output logic                  frame_strobe,
    output logic [FRAME_BITS-1:0] frame_period,
    output logic [LINE_BITS-1:0]  line_count,
    output logic [7:0]            frame_count
);
    localparam int GOOD_BITS = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, TRAIN = 2'd1, LOCKED = 2'd2, RECOVER = 2'd3} state_t;

    logic [1:0]              valid_sync_q, valid_sync_d;
    logic [2:0]              vsync_sync_q, vsync_sync_d;
    logic [2:0]              hsync_sync_q, hsync_sync_d;
    logic                    frame_start_q, frame_start_d;
    logic                    line_q, line_d;
    logic [INVALID_BITS-1:0] invalid_cnt_q, invalid_cnt_d;
    logic                    hdmi_reset_q, hdmi_reset_d;
    logic [FRAME_BITS-1:0]   period_cnt_q, period_cnt_d;
    logic [LINE_BITS-1:0]    line_cnt_q, line_cnt_d;
    logic [FRAME_BITS-1:0]   stored_q, stored_d;
    logic                    have_stored_q, have_stored_d;
    logic [GOOD_BITS-1:0]    good_q, good_d;
    state_t                  state_q, state_d;
    logic                    locked_q, locked_d;
    logic                    frame_strobe_q, frame_strobe_d;
    logic [FRAME_BITS-1:0]   frame_period_q, frame_period_d;
    logic [LINE_BITS-1:0]    line_count_q, line_count_d;
    logic [7:0]              frame_count_q, frame_count_d;

    logic                    valid_s;
    logic                    period_sat;
    logic [FRAME_BITS-1:0]   diff;
    logic                    in_tol;
    logic [GOOD_BITS-1:0]    good_inc;

    assign valid_s    = valid_sync_q[1];
    assign period_sat = &period_cnt_q;
    assign diff       = period_cnt_q >= stored_q ? period_cnt_q - stored_q : stored_q - period_cnt_q;
    assign in_tol     = diff <= (stored_q >> TOL_SHIFT);
    assign good_inc   = good_q + 1'b1;

    // Synchronisers, edge detectors (registered one stage) and the free-running counters
    always_comb begin
        valid_sync_d  = {valid_sync_q[0], hdmi_valid};
        vsync_sync_d  = {vsync_sync_q[1:0], vsync};
        hsync_sync_d  = {hsync_sync_q[1:0], hsync};
        frame_start_d = vsync_sync_q[2] & ~vsync_sync_q[1];
        line_d        = hsync_sync_q[2] & ~hsync_sync_q[1];
        invalid_cnt_d = valid_s ? (invalid_cnt_q == '0 ? invalid_cnt_q : invalid_cnt_q - 1'b1)
                                : (&invalid_cnt_q ? invalid_cnt_q : invalid_cnt_q + 1'b1);
        hdmi_reset_d  = invalid_cnt_q[INVALID_BITS-1];
        period_cnt_d  = frame_start_q ? FRAME_BITS'(1) : (period_sat ? period_cnt_q : period_cnt_q + 1'b1);
        line_cnt_d    = frame_start_q ? LINE_BITS'(line_q)
                                      : (line_q && !(&line_cnt_q) ? line_cnt_q + 1'b1 : line_cnt_q);
    end

    // Link state machine: decoder reset > lost vsync > frame start
    always_comb begin
        state_d        = state_q;
        stored_d       = stored_q;
        have_stored_d  = have_stored_q;
        good_d         = good_q;
        frame_strobe_d = 1'b0;
        frame_period_d = frame_period_q;
        line_count_d   = line_count_q;
        frame_count_d  = frame_count_q;
        if (hdmi_reset_q) begin
            state_d = RECOVER;
        end else if (state_q == RECOVER) begin
            state_d = SEARCH;
        end else if ((state_q == TRAIN || state_q == LOCKED) && period_sat) begin
            state_d = SEARCH;
        end else if (frame_start_q) begin
            if (state_q == SEARCH) begin
                if (valid_s) begin
                    state_d       = TRAIN;
                    have_stored_d = 1'b0;
                    good_d        = '0;
                end
            end else begin
                frame_strobe_d = 1'b1;
                frame_period_d = period_cnt_q;
                line_count_d   = line_cnt_q;
                if (state_q == LOCKED) begin
                    frame_count_d = frame_count_q + 1'b1;
                    if (!in_tol) begin
                        state_d  = TRAIN;
                        stored_d = period_cnt_q;
                        good_d   = '0;
                    end
                end else if (!have_stored_q) begin
                    stored_d      = period_cnt_q;
                    have_stored_d = 1'b1;
                    good_d        = '0;
                end else if (in_tol) begin
                    good_d  = good_inc;
                    state_d = good_inc >= GOOD_BITS'(LOCK_FRAMES) ? LOCKED : TRAIN;
                end else begin
                    stored_d = period_cnt_q;
                    good_d   = '0;
                end
            end
        end
        locked_d = state_d == LOCKED;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_sync_q   <= '0;
            vsync_sync_q   <= '0;
            hsync_sync_q   <= '0;
            frame_start_q  <= 1'b0;
            line_q         <= 1'b0;
            invalid_cnt_q  <= '0;
            hdmi_reset_q   <= 1'b0;
            period_cnt_q   <= '0;
            line_cnt_q     <= '0;
            stored_q       <= '0;
            have_stored_q  <= 1'b0;
            good_q         <= '0;
            state_q        <= SEARCH;
            locked_q       <= 1'b0;
            frame_strobe_q <= 1'b0;
            frame_period_q <= '0;
            line_count_q   <= '0;
            frame_count_q  <= '0;
        end else begin
            valid_sync_q   <= valid_sync_d;
            vsync_sync_q   <= vsync_sync_d;
            hsync_sync_q   <= hsync_sync_d;
            frame_start_q  <= frame_start_d;
            line_q         <= line_d;
            invalid_cnt_q  <= invalid_cnt_d;
            hdmi_reset_q   <= hdmi_reset_d;
            period_cnt_q   <= period_cnt_d;
            line_cnt_q     <= line_cnt_d;
            stored_q       <= stored_d;
            have_stored_q  <= have_stored_d;
            good_q         <= good_d;
            state_q        <= state_d;
            locked_q       <= locked_d;
            frame_strobe_q <= frame_strobe_d;
            frame_period_q <= frame_period_d;
            line_count_q   <= line_count_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign hdmi_reset   = hdmi_reset_q;
    assign locked       = locked_q;
    assign state        = state_q;
    assign frame_strobe = frame_strobe_q;
    assign frame_period = frame_period_q;
    assign line_count   = line_count_q;
    assign frame_count  = frame_count_q;
endmodule

// File: tb/tb_hdmi_link_monitor.sv
// tb_hdmi_link_monitor: directed bench for hdmi_link_monitor with small parameters
module tb_hdmi_link_monitor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hdmi_valid = 1'b0;
    logic        vsync = 1'b0;
    logic        hsync = 1'b0;
    logic        hdmi_reset;
    logic        locked;
    logic [1:0]  state;
    logic        frame_strobe;
    logic [11:0] frame_period;
    logic [11:0] line_count;
    logic [7:0]  frame_count;

    int n_cmp = 0;
    int n_fail = 0;

    logic gen_en = 1'b0;
    logic idle_v = 1'b0;
    logic idle_h = 1'b0;
    int   gen_cnt = 0;
    int   cur_p = 1000;
    int   next_p = 1000;

    hdmi_link_monitor #(
        .INVALID_BITS(4), .LOCK_FRAMES(4), .FRAME_BITS(12), .LINE_BITS(12), .TOL_SHIFT(6)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hdmi_valid(hdmi_valid), .vsync(vsync), .hsync(hsync),
        .hdmi_reset(hdmi_reset), .locked(locked), .state(state), .frame_strobe(frame_strobe),
        .frame_period(frame_period), .line_count(line_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Video timing generator: vsync falls at count 20 of each frame, 10 hsync falls per frame
    initial forever begin
        @(negedge clk);
        if (!gen_en) begin
            gen_cnt = 0;
            cur_p = next_p;
            vsync = idle_v;
            hsync = idle_h;
        end else begin
            if (gen_cnt >= cur_p - 1) begin
                gen_cnt = 0;
                cur_p = next_p;
            end else gen_cnt++;
            vsync = gen_cnt < 20;
            hsync = gen_cnt >= 100 && gen_cnt < 900 && ((gen_cnt - 100) % 80) < 10;
        end
    end

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (frame_strobe) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL strobe_timeout got none exp strobe within 5000 cycles"); end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) begin
            hdmi_valid = 1'($urandom);
            idle_v = 1'($urandom);
            idle_h = 1'($urandom);
            @(posedge clk);
        end
        #1;
        n_cmp++; if (hdmi_reset !== 1'b0) begin n_fail++; $display("FAIL rst_hdmi_reset got %b exp 0", hdmi_reset); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b exp 0", locked); end
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
        n_cmp++; if (frame_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe got %b exp 0", frame_strobe); end
        n_cmp++; if (frame_period !== 12'd0) begin n_fail++; $display("FAIL rst_period got %0d exp 0", frame_period); end
        n_cmp++; if (line_count !== 12'd0) begin n_fail++; $display("FAIL rst_lines got %0d exp 0", line_count); end
        n_cmp++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL rst_fcount got %0d exp 0", frame_count); end
        hdmi_valid = 1'b1;
        idle_v = 1'b0;
        idle_h = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (state !== 2'd0 || hdmi_reset !== 1'b0) begin n_fail++; $display("FAIL post_rst got state %0d hdmi_reset %b exp 0 0", state, hdmi_reset); end
    endtask

    task automatic test_hysteresis;
        int lat;
        int drops;
        @(negedge clk);
        hdmi_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (hdmi_reset) begin lat = i; break; end
        end
        n_cmp++; if (lat != 11) begin n_fail++; $display("FAIL assert_latency got %0d exp 11", lat); end
        hdmi_valid = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!hdmi_reset) begin lat = i; break; end
        end
        n_cmp++; if (lat != 7) begin n_fail++; $display("FAIL deassert_latency got %0d exp 7", lat); end
        n_cmp++; if (state !== 2'd3 || locked !== 1'b0) begin n_fail++; $display("FAIL recover_state got %0d locked %b exp 3 0", state, locked); end
        hdmi_valid = 1'b0;
        drops = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i > 20 && !hdmi_reset) drops++;
        end
        n_cmp++; if (drops != 0) begin n_fail++; $display("FAIL saturate_hold got %0d low cycles exp 0", drops); end
        hdmi_valid = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!hdmi_reset) begin lat = i; break; end
        end
        n_cmp++; if (lat != 11) begin n_fail++; $display("FAIL saturated_release got %0d exp 11", lat); end
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL back_to_search got %0d exp 0", state); end
    endtask

    task automatic test_lock;
        bit ok;
        next_p = 1000;
        @(negedge clk);
        gen_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_strobe(ok);
            n_cmp++; if (frame_period !== 12'd1000) begin n_fail++; $display("FAIL lock_period[%0d] got %0d exp 1000", k, frame_period); end
            n_cmp++; if (line_count !== 12'd10) begin n_fail++; $display("FAIL lock_lines[%0d] got %0d exp 10", k, line_count); end
            n_cmp++; if (locked !== (k == 5)) begin n_fail++; $display("FAIL lock_locked[%0d] got %b exp %b", k, locked, k == 5); end
            n_cmp++; if (state !== (k == 5 ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL lock_state[%0d] got %0d exp %0d", k, state, k == 5 ? 2 : 1); end
        end
        n_cmp++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL lock_fcount got %0d exp 0", frame_count); end
        @(negedge clk);
        n_cmp++; if (frame_strobe !== 1'b0) begin n_fail++; $display("FAIL strobe_width got %b exp 0", frame_strobe); end
    endtask

    task automatic test_tolerance;
        bit ok;
        int set_p[8] = '{1015, 985, 1016, 1016, 1016, 1016, 1016, 1016};
        int exp_p[8] = '{1000, 1015, 985, 1016, 1016, 1016, 1016, 1016};
        int exp_s[8] = '{2, 2, 2, 1, 1, 1, 1, 2};
        int exp_f[8] = '{1, 2, 3, 4, 4, 4, 4, 4};
        for (int k = 0; k < 8; k++) begin
            next_p = set_p[k];
            wait_strobe(ok);
            n_cmp++; if (frame_period !== 12'(exp_p[k])) begin n_fail++; $display("FAIL tol_period[%0d] got %0d exp %0d", k, frame_period, exp_p[k]); end
            n_cmp++; if (state !== 2'(exp_s[k]) || locked !== (exp_s[k] == 2)) begin n_fail++; $display("FAIL tol_state[%0d] got %0d locked %b exp %0d", k, state, locked, exp_s[k]); end
            n_cmp++; if (frame_count !== 8'(exp_f[k])) begin n_fail++; $display("FAIL tol_fcount[%0d] got %0d exp %0d", k, frame_count, exp_f[k]); end
        end
    endtask

    task automatic test_lost_vsync;
        int lat;
        int strobes;
        idle_v = 1'b0;
        gen_en = 1'b0;
        lat = 0;
        strobes = 0;
        for (int i = 1; i <= 6000; i++) begin
            @(negedge clk);
            if (frame_strobe) strobes++;
            if (state == 2'd0) begin lat = i; break; end
        end
        n_cmp++; if (lat != 4095) begin n_fail++; $display("FAIL lost_latency got %0d exp 4095", lat); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lost_locked got %b exp 0", locked); end
        n_cmp++; if (frame_period !== 12'd1016 || line_count !== 12'd10) begin n_fail++; $display("FAIL lost_hold got %0d/%0d exp 1016/10", frame_period, line_count); end
        n_cmp++; if (strobes != 0 || frame_count !== 8'd4) begin n_fail++; $display("FAIL lost_quiet got strobes %0d fcount %0d exp 0 4", strobes, frame_count); end
    endtask

    task automatic test_reset_mid_lock;
        bit ok;
        bit seen;
        next_p = 1000;
        @(negedge clk);
        gen_en = 1'b1;
        for (int k = 1; k <= 5; k++) wait_strobe(ok);
        n_cmp++; if (state !== 2'd2 || frame_count !== 8'd4) begin n_fail++; $display("FAIL relock got state %0d fcount %0d exp 2 4", state, frame_count); end
        hdmi_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hdmi_reset) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_reset_assert got 0 exp 1"); end
        @(negedge clk);
        n_cmp++; if (state !== 2'd3 || locked !== 1'b0) begin n_fail++; $display("FAIL mid_recover got state %0d locked %b exp 3 0", state, locked); end
        n_cmp++; if (frame_count !== 8'd4 || frame_period !== 12'd1000) begin n_fail++; $display("FAIL mid_hold got fcount %0d period %0d exp 4 1000", frame_count, frame_period); end
        hdmi_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (state == 2'd0) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_search got state %0d exp 0", state); end
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (state == 2'd1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen || frame_count !== 8'd4 || locked !== 1'b0) begin n_fail++; $display("FAIL mid_train got state %0d fcount %0d locked %b exp 1 4 0", state, frame_count, locked); end
    endtask

    initial begin
        test_reset;
        test_hysteresis;
        test_lock;
        test_tolerance;
        test_lost_vsync;
        test_reset_mid_lock;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
